// File: rtl/hsv_cfg_scheduler.sv
// Colour-reduce configuration scheduler: applies one sel/val write per vertical blank
// with setup/strobe timing. Optional readback shadows are enabled by HSV_CFG_READBACK_EN.
module hsv_cfg_scheduler #(
    parameter int SETUP_CYCLES = 1,
    parameter int HOLD_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_sel,
    input  logic [2:0] req_val,
    output logic       req_ready,
    input  logic       vblank,
    output logic [1:0] switch_sels,
    output logic [2:0] switch_vals,
    output logic       change,
    output logic       busy,
    output logic       applied
`ifdef HSV_CFG_READBACK_EN
    ,
    input  logic [1:0] rd_sel,
    output logic [2:0] rd_val
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BLANK,
        SETUP,
        STROBE,
        DONE
    } state_t;

    // Counters hold remaining cycles minus one, so a phase ends when the counter reads zero.
    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYCLES - 1);

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [1:0] cap_sel_q;
    logic [2:0] cap_val_q;
    logic [1:0] sels_q;
    logic [2:0] vals_q;
    logic       change_q;
    logic       busy_q;
    logic       applied_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cap_sel_q <= '0;
            cap_val_q <= '0;
            sels_q    <= '0;
            vals_q    <= '0;
            change_q  <= 1'b0;
            busy_q    <= 1'b0;
            applied_q <= 1'b0;
        end else begin
            applied_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        cap_sel_q <= req_sel;
                        cap_val_q <= req_val;
                        busy_q    <= 1'b1;
                        state_q   <= WAIT_BLANK;
                    end
                end
                WAIT_BLANK: begin
                    // Outputs to the colour-reduce instances only move on entry to SETUP.
                    if (vblank) begin
                        sels_q  <= cap_sel_q;
                        vals_q  <= cap_val_q;
                        cnt_q   <= SETUP_LD;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == 4'd0) begin
                        cnt_q    <= HOLD_LD;
                        change_q <= 1'b1;
                        state_q  <= STROBE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                STROBE: begin
                    if (cnt_q == 4'd0) begin
                        cnt_q     <= '0;
                        change_q  <= 1'b0;
                        applied_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    change_q <= 1'b0;
                    busy_q   <= 1'b0;
                    cnt_q    <= '0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = ~busy_q;
    assign busy        = busy_q;
    assign change      = change_q;
    assign applied     = applied_q;
    assign switch_sels = sels_q;
    assign switch_vals = vals_q;

`ifdef HSV_CFG_READBACK_EN
    logic [2:0] shadow_q [4];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (state_q == DONE) begin
            shadow_q[cap_sel_q] <= cap_val_q;
        end
    end

    assign rd_val = shadow_q[rd_sel];
`endif

endmodule

// File: doc/hsv_cfg_scheduler.md
HSV_CFG_SCHEDULER -- requirements
Module: hsv_cfg_scheduler

Interface
REQ-001 Parameter SETUP_CYCLES, default 1: cycles sels/vals are driven stable before `change` rises; legal range 1..15.
REQ-002 Parameter HOLD_CYCLES, default 2: cycles `change` is held high; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  requester has a colour-reduce configuration write pending.
REQ-006 req_sel  input  2  target selector for the write.
REQ-007 req_val  input  3  value for the write.
REQ-008 req_ready  output  1  scheduler can accept a write; high only in IDLE.
REQ-009 vblank  input  1  display vertical blanking; high means safe to reconfigure.
REQ-010 switch_sels  output  2  selector driven to both colour-reduce instances.
REQ-011 switch_vals  output  3  value driven to both colour-reduce instances.
REQ-012 change  output  1  level strobe to colour-reduce instances.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 applied  output  1  one-cycle pulse when a write completes.

Function
REQ-015 A write SHALL be accepted on a rising edge where req_valid and req_ready are both high; req_sel/req_val SHALL be captured at that edge.
REQ-016 States SHALL be IDLE, WAIT_BLANK, SETUP, STROBE, DONE.
REQ-017 IDLE->WAIT_BLANK on acceptance; otherwise remain in IDLE.
REQ-018 WAIT_BLANK->SETUP at the first edge with vblank high; otherwise remain, with no timeout.
REQ-019 SETUP SHALL last exactly SETUP_CYCLES cycles with the captured sel/val on switch_sels/switch_vals and change low.
REQ-020 STROBE SHALL last exactly HOLD_CYCLES cycles with change high and switch_sels/switch_vals unchanged.
REQ-021 DONE SHALL last one cycle with applied high and change low, then return to IDLE.
REQ-022 Once in SETUP, the sequence SHALL complete even if vblank falls.
REQ-023 switch_sels/switch_vals SHALL update only on entry to SETUP and SHALL otherwise hold their last applied value.
REQ-024 Timing: acceptance at edge k with vblank high at k+1 gives SETUP from k+2, STROBE from k+2+SETUP_CYCLES, DONE at k+2+SETUP_CYCLES+HOLD_CYCLES, and req_ready at the following cycle.
REQ-025 req_valid during busy SHALL be ignored and not queued; the requester SHALL hold it.
REQ-026 Phase counters SHALL be 4 bits and SHALL reload on each state entry.

Reset
REQ-027 Asserting reset SHALL immediately force IDLE, switch_sels=0, switch_vals=0, change=0, busy=0, applied=0, and clear the counters and captured request.
REQ-028 Reset mid-STROBE SHALL drop change the same instant without an applied pulse.
REQ-029 After reset deasserts, req_ready SHALL be high on the first cycle.

Configuration
REQ-030 Macro HSV_CFG_READBACK_EN, when defined, SHALL add input rd_sel[1:0] and output rd_val[2:0], plus four 3-bit shadow registers written in DONE with the applied value.
REQ-031 With HSV_CFG_READBACK_EN, rd_val SHALL combinationally return the shadow for rd_sel, and all shadows SHALL reset to 0.
REQ-032 Without HSV_CFG_READBACK_EN, those ports and registers SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 Defaults, vblank=1, write sel=2 val=5 at edge 10: switch_sels=2 and switch_vals=5 from cycle 12; change high in cycles 13-14; applied in cycle 15; req_ready in cycle 16.
REQ-034 vblank=0 for 50 cycles after acceptance: change stays 0 and busy stays 1; after vblank rises, change rises SETUP_CYCLES+1 cycles later.
REQ-035 vblank drops during SETUP: full STROBE still occurs and applied is still asserted.
REQ-036 reset asserted in first STROBE cycle: change=0 and switch_sels=0/switch_vals=0 immediately; no applied pulse; req_ready=1 after release.
REQ-037 Back-to-back writes (1,3) then (1,6) with req_valid held high: second accepted only in the cycle after DONE; switch_vals shows 3 then 6.
REQ-038 HSV_CFG_READBACK_EN: after writes (0,7) and (3,1), rd_sel=0 returns 7, rd_sel=3 returns 1, rd_sel=1 returns 0.
